// File: rtl/wire_game_pkg.sv
// -----------------------------------------------------------------------------
// wire_game_pkg
//   Shared types and constants for the wire-cutting pause/judge logic.
//   Optional feature macro used by the consumers: WIRE_STRIKES_EN.
// -----------------------------------------------------------------------------
package wire_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAUSED,
        RUN,
        DEFUSED,
        EXPLODED
    } wire_state_e;

    // Colour code that means "nothing selected".
    localparam int COLOUR_NONE    = 0;
    // Seconds removed from the countdown on each wrong cut (strike builds only).
    localparam int STRIKE_PENALTY = 5;

endpackage

// File: rtl/colour_hold_debounce.sv
// -----------------------------------------------------------------------------
// colour_hold_debounce
//   Tracks how long the selected colour has been stable and emits a one-cycle
//   cut pulse, carrying the colour, when a nonzero colour has been held for
//   HOLD_CYCLES consecutive cycles.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   colour_i     currently selected colour (already synchronised)
//   cut_o        one-cycle pulse: hold threshold reached
//   cut_colour_o colour that was held, valid with cut_o
// -----------------------------------------------------------------------------
module colour_hold_debounce
    import wire_game_pkg::*;
#(
    parameter int COLOUR_W    = 3,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COLOUR_W-1:0] colour_i,
    output logic                cut_o,
    output logic [COLOUR_W-1:0] cut_colour_o
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [COLOUR_W-1:0] prev_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cut_q, cut_d;
    logic [COLOUR_W-1:0] cut_colour_q;
    logic                changed;
    logic                selected;

    assign selected = (colour_i != COLOUR_W'(COLOUR_NONE));
    assign changed  = (colour_i != prev_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!selected || changed) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Counter saturates at LAST; fire only on the cycle it arrives there,
        // so a long hold produces a single pulse.
        cut_d = selected && (cnt_d == LAST) && (changed || (cnt_q != LAST));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q       <= '0;
            cnt_q        <= '0;
            cut_q        <= 1'b0;
            cut_colour_q <= '0;
        end else begin
            prev_q       <= colour_i;
            cnt_q        <= cnt_d;
            cut_q        <= cut_d;
            cut_colour_q <= colour_i;
        end
    end

    assign cut_o        = cut_q;
    assign cut_colour_o = cut_colour_q;

endmodule

// File: rtl/wire_pause_ctrl.sv
// -----------------------------------------------------------------------------
// wire_pause_ctrl
//   Game controller for the wire-cutting stage: pauses the countdown while no
//   colour is selected, debounces colour selections into cuts, and judges each
//   cut against the target wire to produce defused/exploded outcomes.
//
//   Optional feature: define WIRE_STRIKES_EN to tolerate wrong cuts (strike
//   counter, time penalty, explosion at MAX_STRIKES). Without it the first
//   wrong cut explodes and strikes stays 0.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   start        one-cycle pulse: load timer, latch target, begin game
//   time_init    countdown start value (sampled on start)
//   tick         one-cycle 1 Hz enable
//   wire_to_cut  target colour (sampled on start)
//   curr_colour  currently selected colour, 0 = none
//   pause        1 = timer frozen
//   time_left    remaining seconds
//   defused      sticky success flag
//   exploded     sticky failure flag
//   strikes      wrong-cut count
// -----------------------------------------------------------------------------
module wire_pause_ctrl
    import wire_game_pkg::*;
#(
    parameter int COLOUR_W    = 3,
    parameter int HOLD_CYCLES = 1000,
    parameter int TIMER_W     = 8,
    parameter int MAX_STRIKES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [TIMER_W-1:0]  time_init,
    input  logic                tick,
    input  logic [COLOUR_W-1:0] wire_to_cut,
    input  logic [COLOUR_W-1:0] curr_colour,
    output logic                pause,
    output logic [TIMER_W-1:0]  time_left,
    output logic                defused,
    output logic                exploded,
    output logic [1:0]          strikes
);

    localparam logic [TIMER_W-1:0] ONE       = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] PENALTY_T = TIMER_W'(STRIKE_PENALTY);

    wire_state_e         state_q, state_d;
    logic [TIMER_W-1:0]  time_q, time_d;
    logic [COLOUR_W-1:0] target_q, target_d;
    logic [1:0]          strikes_q, strikes_d;
    logic                armed_q, armed_d;
    logic                pause_q, pause_d;
    logic                defused_q, defused_d;
    logic                exploded_q, exploded_d;

    logic                cut;
    logic [COLOUR_W-1:0] cut_colour;
    logic                colour_none;

    assign colour_none = (curr_colour == COLOUR_W'(COLOUR_NONE));

    colour_hold_debounce #(
        .COLOUR_W    (COLOUR_W),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk          (clk),
        .rst          (rst),
        .colour_i     (curr_colour),
        .cut_o        (cut),
        .cut_colour_o (cut_colour)
    );

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        target_d   = target_q;
        strikes_d  = strikes_q;
        armed_d    = armed_q;
        defused_d  = defused_q;
        exploded_d = exploded_q;

        case (state_q)
            PAUSED: begin
                if (!colour_none) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Cut is resolved before the tick of the same cycle.
                if (cut && armed_q) begin
                    armed_d = 1'b0;
                    if (cut_colour == target_q) begin
                        state_d   = DEFUSED;
                        defused_d = 1'b1;
                    end else begin
`ifdef WIRE_STRIKES_EN
                        strikes_d = strikes_q + 2'd1;
                        time_d    = (time_q <= PENALTY_T) ? '0 : (time_q - PENALTY_T);
                        if ((({30'b0, strikes_q} + 32'd1) >= MAX_STRIKES) ||
                            (time_q <= PENALTY_T)) begin
                            state_d    = EXPLODED;
                            exploded_d = 1'b1;
                        end
`else
                        state_d    = EXPLODED;
                        exploded_d = 1'b1;
`endif
                    end
                end
                if (state_d == RUN && tick) begin
                    if (time_d <= ONE) begin
                        time_d     = '0;
                        state_d    = EXPLODED;
                        exploded_d = 1'b1;
                    end else begin
                        time_d = time_d - ONE;
                    end
                end
                if (state_d == RUN && colour_none) begin
                    state_d = PAUSED;
                    armed_d = 1'b1;
                end
            end
            default: ;  // IDLE and terminal states wait for start
        endcase

        if (start) begin
            time_d     = time_init;
            target_d   = wire_to_cut;
            strikes_d  = '0;
            armed_d    = 1'b0;
            defused_d  = 1'b0;
            if (time_init == '0) begin
                state_d    = EXPLODED;
                exploded_d = 1'b1;
            end else begin
                state_d    = PAUSED;
                exploded_d = 1'b0;
            end
        end

`ifndef WIRE_STRIKES_EN
        strikes_d = '0;
`endif
        // Registered pause follows the next state so it lines up with it.
        pause_d = (state_d != RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            time_q     <= '0;
            target_q   <= '0;
            strikes_q  <= '0;
            armed_q    <= 1'b1;
            pause_q    <= 1'b1;
            defused_q  <= 1'b0;
            exploded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            target_q   <= target_d;
            strikes_q  <= strikes_d;
            armed_q    <= armed_d;
            pause_q    <= pause_d;
            defused_q  <= defused_d;
            exploded_q <= exploded_d;
        end
    end

    assign pause     = pause_q;
    assign time_left = time_q;
    assign defused   = defused_q;
    assign exploded  = exploded_q;
    assign strikes   = strikes_q;

endmodule

// File: tb/tb_wire_pause_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wire_pause_ctrl
//   Directed bench for wire_pause_ctrl with HOLD_CYCLES=4. Expected output
//   snapshots are queued as stimulus is applied and compared once the DUT
//   has clocked. Strike scenarios are built when WIRE_STRIKES_EN is defined.
// -----------------------------------------------------------------------------
module tb_wire_pause_ctrl;

    localparam int CW   = 3;
    localparam int HOLD = 4;
    localparam int TW   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [TW-1:0] time_init;
    logic          tick;
    logic [CW-1:0] wire_to_cut;
    logic [CW-1:0] curr_colour;
    logic          pause;
    logic [TW-1:0] time_left;
    logic          defused;
    logic          exploded;
    logic [1:0]    strikes;

    wire_pause_ctrl #(
        .COLOUR_W    (CW),
        .HOLD_CYCLES (HOLD),
        .TIMER_W     (TW),
        .MAX_STRIKES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .time_init   (time_init),
        .tick        (tick),
        .wire_to_cut (wire_to_cut),
        .curr_colour (curr_colour),
        .pause       (pause),
        .time_left   (time_left),
        .defused     (defused),
        .exploded    (exploded),
        .strikes     (strikes)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          p;
        logic [TW-1:0] t;
        logic          d;
        logic          e;
        logic [1:0]    s;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic p, input int t,
                              input logic d, input logic e, input int s);
        exp_t x;
        x.p = p;
        x.t = TW'(t);
        x.d = d;
        x.e = e;
        x.s = 2'(s);
        exp_q.push_back(x);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        exp_t  x;
        string tag;
        while (exp_q.size() > 0) begin
            x   = exp_q.pop_front();
            tag = tag_q.pop_front();
            n_tests++;
            assert (pause === x.p) else begin
                n_fail++;
                $error("FAIL %s.pause got %0b want %0b", tag, pause, x.p);
            end
            n_tests++;
            assert (time_left === x.t) else begin
                n_fail++;
                $error("FAIL %s.time_left got %0d want %0d", tag, time_left, x.t);
            end
            n_tests++;
            assert (defused === x.d) else begin
                n_fail++;
                $error("FAIL %s.defused got %0b want %0b", tag, defused, x.d);
            end
            n_tests++;
            assert (exploded === x.e) else begin
                n_fail++;
                $error("FAIL %s.exploded got %0b want %0b", tag, exploded, x.e);
            end
            n_tests++;
            assert (strikes === x.s) else begin
                n_fail++;
                $error("FAIL %s.strikes got %0d want %0d", tag, strikes, x.s);
            end
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic do_start(input int ti, input int tgt);
        time_init   = TW'(ti);
        wire_to_cut = CW'(tgt);
        start       = 1'b1;
        step(1);
        start       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        tick        = 1'b0;
        time_init   = '0;
        wire_to_cut = '0;
        curr_colour = '0;
        #12;
        expect_out("reset", 1'b1, 0, 1'b0, 1'b0, 0);
        check_out();
        rst = 1'b0;
        step(1);

        // Pause gating: no colour selected, ticks are ignored.
        do_start(10, 3);
        for (int i = 0; i < 5; i++) begin
            pulse_tick();
            step(1);
        end
        expect_out("pause_gate", 1'b1, 10, 1'b0, 1'b0, 0);
        check_out();

        // Short hold then release: runs briefly, no cut, re-arms.
        curr_colour = 3'd3;
        step(3);
        expect_out("short_hold", 1'b0, 10, 1'b0, 1'b0, 0);
        check_out();
        curr_colour = 3'd0;
        step(1);
        expect_out("release", 1'b1, 10, 1'b0, 1'b0, 0);
        check_out();

        // Full hold: cut pulse after 4 edges, judged on the 5th with a tick.
        curr_colour = 3'd3;
        step(4);
        expect_out("hold4", 1'b0, 10, 1'b0, 1'b0, 0);
        check_out();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        expect_out("defuse_tick", 1'b1, 10, 1'b1, 1'b0, 0);
        check_out();
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
        end
        expect_out("defused_frozen", 1'b1, 10, 1'b1, 1'b0, 0);
        check_out();

        // Timeout with a wrong colour held (not armed after start).
        curr_colour = 3'd5;
        do_start(2, 3);
        expect_out("to_start", 1'b1, 2, 1'b0, 1'b0, 0);
        check_out();
        step(1);
        pulse_tick();
        expect_out("to_tick1", 1'b0, 1, 1'b0, 1'b0, 0);
        check_out();
        pulse_tick();
        expect_out("to_tick2", 1'b1, 0, 1'b0, 1'b1, 0);
        check_out();
        pulse_tick();
        step(3);
        expect_out("to_frozen", 1'b1, 0, 1'b0, 1'b1, 0);
        check_out();

`ifdef WIRE_STRIKES_EN
        curr_colour = 3'd0;
        do_start(20, 3);
        curr_colour = 3'd5;
        step(1);
        curr_colour = 3'd0;
        step(1);
        curr_colour = 3'd5;
        step(5);
        expect_out("strike1", 1'b0, 15, 1'b0, 1'b0, 1);
        check_out();
        step(6);
        expect_out("strike1_hold", 1'b0, 15, 1'b0, 1'b0, 1);
        check_out();
        curr_colour = 3'd0;
        step(1);
        curr_colour = 3'd5;
        step(5);
        expect_out("strike2", 1'b0, 10, 1'b0, 1'b0, 2);
        check_out();
        step(6);
        expect_out("strike2_hold", 1'b0, 10, 1'b0, 1'b0, 2);
        check_out();
        curr_colour = 3'd0;
        step(1);
        curr_colour = 3'd5;
        step(5);
        expect_out("strike3", 1'b1, 5, 1'b0, 1'b1, 3);
        check_out();
`else
        curr_colour = 3'd0;
        do_start(20, 3);
        curr_colour = 3'd5;
        step(1);
        curr_colour = 3'd0;
        step(1);
        curr_colour = 3'd5;
        step(1);
        pulse_tick();
        step(2);
        expect_out("wrong_pending", 1'b0, 19, 1'b0, 1'b0, 0);
        check_out();
        step(1);
        expect_out("wrong_cut", 1'b1, 19, 1'b0, 1'b1, 0);
        check_out();
`endif

        // Zero start time explodes at once.
        curr_colour = 3'd0;
        do_start(0, 3);
        expect_out("zero_time", 1'b1, 0, 1'b0, 1'b1, 0);
        check_out();

        // Asynchronous reset in the middle of a running game.
        do_start(9, 3);
        curr_colour = 3'd4;
        step(1);
        pulse_tick();
        pulse_tick();
        expect_out("mid_run", 1'b0, 7, 1'b0, 1'b0, 0);
        check_out();
        #2;
        rst = 1'b1;
        #1;
        expect_out("async_rst", 1'b1, 0, 1'b0, 1'b0, 0);
        check_out();
        curr_colour = 3'd0;
        #3;
        rst = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
